// File: rtl/reg_scoreboard_pkg.sv
// Shared types and constants for the dual-issue register hazard scoreboard.
// A candidate instruction is carried as one packed struct per pipe.
package reg_scoreboard_pkg;

   localparam int SIZE    = 128;
   localparam int LOGSIZE = $clog2(SIZE);
   localparam int MAX_LAT = 7;
   localparam int LATW    = $clog2(MAX_LAT + 1);

   // Producer latencies (issue to register-file write) of the execution units.
   localparam int LAT_SIMPLE_FX = 2;
   localparam int LAT_SP_FP     = 6;
   localparam int LAT_LOAD      = 6;
   localparam int LAT_PERM      = 3;

   typedef logic [LOGSIZE-1:0] reg_addr_t;
   typedef logic [LATW-1:0]    lat_t;

   typedef struct packed {
      logic      valid;
      reg_addr_t ra_addr;
      reg_addr_t rb_addr;
      reg_addr_t rc_addr;
      logic      ra_used;
      logic      rb_used;
      logic      rc_used;
      reg_addr_t rt_addr;
      logic      wr;
      lat_t      lat;
   } cand_t;

   function automatic logic lat_legal(input lat_t lat);
      return (lat != lat_t'(0)) && (lat <= lat_t'(MAX_LAT));
   endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue-stage interface: decode drives the two candidates (master), the
// scoreboard returns the issue decisions (slave).
interface reg_scoreboard_if;
   import reg_scoreboard_pkg::*;

   cand_t even_in;
   cand_t odd_in;
   logic  issue_even_out;
   logic  issue_odd_out;
   logic  stall_out;
   logic  idle_out;

   modport master (
      output even_in, odd_in,
      input  issue_even_out, issue_odd_out, stall_out, idle_out
   );

   modport slave (
      input  even_in, odd_in,
      output issue_even_out, issue_odd_out, stall_out, idle_out
   );

endinterface

// File: rtl/reg_scoreboard_chk.sv
// Simulation checks on the scoreboard inputs and issue decisions.
module reg_scoreboard_chk
   import reg_scoreboard_pkg::*;
(
   input logic  clk,
   input logic  rst_n,
   input cand_t even_in,
   input cand_t odd_in,
   input logic  issue_even,
   input logic  issue_odd
);

   a_even_lat: assert property (@(posedge clk) disable iff (!rst_n)
      (even_in.valid && even_in.wr) |-> lat_legal(even_in.lat));

   a_odd_lat: assert property (@(posedge clk) disable iff (!rst_n)
      (odd_in.valid && odd_in.wr) |-> lat_legal(odd_in.lat));

   a_no_dual_load: assert property (@(posedge clk) disable iff (!rst_n)
      !(issue_even && issue_odd && even_in.wr && odd_in.wr &&
        (even_in.rt_addr == odd_in.rt_addr)));

   a_in_order: assert property (@(posedge clk) disable iff (!rst_n)
      (issue_odd && even_in.valid) |-> issue_even);

endmodule

// File: rtl/reg_scoreboard_counter.sv
// Per-register in-flight countdown: loads the producer latency on issue and
// counts down to zero, where the result is readable from the register file.
module reg_scoreboard_counter
   import reg_scoreboard_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  lat_t lat_i,
   output lat_t cnt_o,
   output logic busy_o
);

   lat_t cnt_q;
   lat_t cnt_d;

   // Next count: a new load wins over the decrement of an older producer.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = lat_i;
      end else if (cnt_q != lat_t'(0)) begin
         cnt_d = cnt_q - lat_t'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= lat_t'(0);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign busy_o = (cnt_q != lat_t'(0));

endmodule

// File: rtl/reg_scoreboard.sv
// Dual-issue RAW/WAW hazard scoreboard: one countdown per register, issue
// decided combinationally from the counters and the two candidates.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
(
   input logic             clk,
   input logic             rst_n,
   reg_scoreboard_if.slave sb
);

   cand_t           e_s;
   cand_t           o_s;
   lat_t            cnt_s [SIZE];
   logic [SIZE-1:0] busy_s;
   logic            haz_e_s;
   logic            haz_o_s;
   logic            pair_dep_s;
   logic            issue_e_s;
   logic            issue_o_s;

   assign e_s = sb.even_in;
   assign o_s = sb.odd_in;

   function automatic logic reads_reg(input cand_t c, input reg_addr_t addr);
      return (c.ra_used && (c.ra_addr == addr)) ||
             (c.rb_used && (c.rb_addr == addr)) ||
             (c.rc_used && (c.rc_addr == addr));
   endfunction

   function automatic logic src_busy(input cand_t c, input logic [SIZE-1:0] busy);
      return (c.ra_used && busy[c.ra_addr]) ||
             (c.rb_used && busy[c.rb_addr]) ||
             (c.rc_used && busy[c.rc_addr]);
   endfunction

   // Hazards and issue; a later writer may not finish before an older one (WAW).
   always_comb begin
      haz_e_s    = src_busy(e_s, busy_s) ||
                   (e_s.wr && (cnt_s[e_s.rt_addr] > e_s.lat));
      issue_e_s  = e_s.valid && !haz_e_s;
      pair_dep_s = issue_e_s && e_s.wr &&
                   (reads_reg(o_s, e_s.rt_addr) ||
                    (o_s.wr && (o_s.rt_addr == e_s.rt_addr)));
      haz_o_s    = src_busy(o_s, busy_s) ||
                   (o_s.wr && (cnt_s[o_s.rt_addr] > o_s.lat)) || pair_dep_s;
      issue_o_s  = o_s.valid && !haz_o_s && (issue_e_s || !e_s.valid);
   end

   assign sb.issue_even_out = issue_e_s;
   assign sb.issue_odd_out  = issue_o_s;
   assign sb.stall_out      = (e_s.valid && !issue_e_s) || (o_s.valid && !issue_o_s);
   assign sb.idle_out       = ~|busy_s;

   for (genvar i = 0; i < SIZE; i++) begin : g_cnt
      logic ld_e_s;
      logic ld_o_s;
      lat_t ld_lat_s;

      assign ld_e_s   = issue_e_s && e_s.wr && (e_s.rt_addr == reg_addr_t'(i));
      assign ld_o_s   = issue_o_s && o_s.wr && (o_s.rt_addr == reg_addr_t'(i));
      assign ld_lat_s = ld_e_s ? e_s.lat : o_s.lat;

      reg_scoreboard_counter u_cnt (
         .clk    (clk),
         .rst_n  (rst_n),
         .load_i (ld_e_s || ld_o_s),
         .lat_i  (ld_lat_s),
         .cnt_o  (cnt_s[i]),
         .busy_o (busy_s[i])
      );
   end

   reg_scoreboard_chk u_chk (
      .clk        (clk),
      .rst_n      (rst_n),
      .even_in    (e_s),
      .odd_in     (o_s),
      .issue_even (issue_e_s),
      .issue_odd  (issue_o_s)
   );

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed hazard scenarios plus
// randomized dual-issue traffic against a per-register countdown model.
module tb_reg_scoreboard;
   import reg_scoreboard_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   mcnt [SIZE];

   reg_scoreboard_if sb ();

   reg_scoreboard dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (sb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic cand_t nop_c();
      cand_t c;
      c = '0;
      return c;
   endfunction

   function automatic cand_t wr_c(input int rt, input int lat);
      cand_t c;
      c = '0;
      c.valid   = 1'b1;
      c.wr      = 1'b1;
      c.rt_addr = reg_addr_t'(rt);
      c.lat     = lat_t'(lat);
      return c;
   endfunction

   function automatic cand_t rd_c(input int ra);
      cand_t c;
      c = '0;
      c.valid   = 1'b1;
      c.ra_used = 1'b1;
      c.ra_addr = reg_addr_t'(ra);
      c.lat     = lat_t'(1);
      return c;
   endfunction

   function automatic cand_t rand_c();
      cand_t c;
      c.valid   = ($urandom_range(0, 9) < 8);
      c.ra_addr = reg_addr_t'($urandom_range(0, 15));
      c.rb_addr = reg_addr_t'($urandom_range(0, 15));
      c.rc_addr = reg_addr_t'($urandom_range(0, 15));
      c.ra_used = 1'($urandom_range(0, 1));
      c.rb_used = 1'($urandom_range(0, 1));
      c.rc_used = 1'($urandom_range(0, 1));
      c.rt_addr = reg_addr_t'($urandom_range(0, 15));
      c.wr      = ($urandom_range(0, 3) != 0);
      c.lat     = lat_t'($urandom_range(1, MAX_LAT));
      return c;
   endfunction

   // A register is pending while its result is still some cycles away.
   function automatic bit pending(input int r);
      return mcnt[r] > 0;
   endfunction

   function automatic bit needs(input cand_t c, input int r);
      return (c.ra_used && int'(c.ra_addr) == r) || (c.rb_used && int'(c.rb_addr) == r) ||
             (c.rc_used && int'(c.rc_addr) == r);
   endfunction

   function automatic bit may_go(input cand_t c);
      for (int r = 0; r < SIZE; r++) begin
         if (needs(c, r) && pending(r)) return 1'b0;
      end
      if (c.wr && mcnt[c.rt_addr] > int'(c.lat)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit all_done();
      foreach (mcnt[r]) if (mcnt[r] != 0) return 1'b0;
      return 1'b1;
   endfunction

   // Drive one cycle, compare against the model, then advance the model.
   task automatic step(input cand_t e, input cand_t o, output bit ie, output bit io);
      bit xe, xo, xst;
      @(negedge clk);
      sb.even_in = e;
      sb.odd_in  = o;
      #1;
      xe = e.valid && may_go(e);
      xo = o.valid && may_go(o) && (xe || !e.valid);
      if (xe && e.wr && (needs(o, int'(e.rt_addr)) || (o.wr && o.rt_addr == e.rt_addr)))
         xo = 1'b0;
      xst = (e.valid && !xe) || (o.valid && !xo);
      check_val("issue_even", 32'(sb.issue_even_out), 32'(xe));
      check_val("issue_odd",  32'(sb.issue_odd_out),  32'(xo));
      check_val("stall",      32'(sb.stall_out),      32'(xst));
      check_val("idle",       32'(sb.idle_out),       32'(all_done()));
      ie = sb.issue_even_out;
      io = sb.issue_odd_out;
      foreach (mcnt[r]) if (mcnt[r] > 0) mcnt[r]--;
      if (xe && e.wr) mcnt[e.rt_addr] = int'(e.lat);
      if (xo && o.wr) mcnt[o.rt_addr] = int'(o.lat);
   endtask

   task automatic drain();
      bit ie, io;
      for (int i = 0; i < 16 && !all_done(); i++) step(nop_c(), nop_c(), ie, io);
      check_val("drained_model", 32'(all_done()), 32'd1);
   endtask

   initial begin
      bit ie, io;
      n_checks = 0;
      n_fail   = 0;
      foreach (mcnt[r]) mcnt[r] = 0;
      rst_n      = 1'b0;
      sb.even_in = rd_c(4);
      sb.odd_in  = rd_c(5);
      repeat (2) @(negedge clk);
      #1;
      check_val("rst_idle",  32'(sb.idle_out),       32'd1);
      check_val("rst_issue_even", 32'(sb.issue_even_out), 32'd1);
      check_val("rst_issue_odd",  32'(sb.issue_odd_out),  32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // RAW: reader of r5 stalls while cnt is 2 and 1, issues when 0.
      step(wr_c(5, 2), nop_c(), ie, io);
      check_val("raw_wr_issue", 32'(ie), 32'd1);
      for (int k = 0; k < 3; k++) begin
         step(rd_c(5), nop_c(), ie, io);
         check_val("raw_rd", 32'(ie), 32'(k == 2));
      end
      drain();

      // Same-cycle pair dependency.
      step(wr_c(10, 3), rd_c(10), ie, io);
      check_val("pair_even", 32'(ie), 32'd1);
      check_val("pair_odd",  32'(io), 32'd0);
      check_val("pair_stall", 32'(sb.stall_out), 32'd1);
      drain();

      // In-order: odd cannot pass a stalled even.
      step(wr_c(3, 5), nop_c(), ie, io);
      step(rd_c(3), wr_c(101, 2), ie, io);
      check_val("inorder_even", 32'(ie), 32'd0);
      check_val("inorder_odd",  32'(io), 32'd0);
      drain();

      // WAW: lat-2 writer waits until the lat-6 producer's count drops to 2.
      step(wr_c(7, 6), nop_c(), ie, io);
      for (int k = 0; k < 5; k++) begin
         step(wr_c(7, 2), nop_c(), ie, io);
         check_val("waw", 32'(ie), 32'(k == 4));
      end
      drain();

      // Reload on the edge where the count would reach zero.
      step(wr_c(9, 1), nop_c(), ie, io);
      step(wr_c(9, 4), nop_c(), ie, io);
      check_val("reload_issue", 32'(ie), 32'd1);
      for (int k = 0; k < 5; k++) begin
         step(rd_c(9), nop_c(), ie, io);
         check_val("reload_rd", 32'(ie), 32'(k == 4));
      end
      drain();

      // Asynchronous reset with many registers in flight.
      for (int k = 0; k < 10; k++) step(wr_c(20 + 2 * k, 7), wr_c(21 + 2 * k, 7), ie, io);
      @(negedge clk);
      sb.even_in = nop_c();
      sb.odd_in  = nop_c();
      #1;
      check_val("busy_before_rst", 32'(sb.idle_out), 32'd0);
      #1;
      rst_n = 1'b0;
      #1;
      check_val("async_rst_idle", 32'(sb.idle_out), 32'd1);
      foreach (mcnt[r]) mcnt[r] = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step(rd_c(38 - 2 * k), rd_c(39 - 2 * k), ie, io);
         check_val("post_rst_rd", 32'({ie, io}), 32'd3);
      end

      // Randomized dual-issue traffic on a small register window.
      for (int n = 0; n < 600; n++) step(rand_c(), rand_c(), ie, io);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
